img_mem_arbiter: RTL and testbench

Two-requester arbiter sharing the coprocessor's single-port image memory between the host loader (port A: writes the image, reads back results) and the pixel scan engine (port B: reads pixels in raster order). It sits between both requesters and the memory macro, grants one owner at a time with round-robin tie-breaking and a bounded burst length, and routes read data back to the port that issued the read.

---
 rtl/img_mem_arbiter_pkg.sv | 24 ++
 rtl/img_mem_arbiter_if.sv | 39 +++
 rtl/img_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_img_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/img_mem_arbiter_pkg.sv
// ------------------------------------------------------------------
// coproc_pkg: shared coprocessor encodings and image geometry. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package coproc_pkg;

  localparam int IMG_ADDR_W = 8;
  localparam int IMG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

endpackage

`default_nettype wire

// File: rtl/img_mem_arbiter_if.sv
// ------------------------------------------------------------------
// img_mem_arbiter_if: both requester ports plus the memory macro port. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface img_mem_arbiter_if
  import coproc_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = IMG_DATA_W
);
  logic              a_req,    b_req;
  logic              a_we,     b_we;
  logic [ADDR_W-1:0] a_addr,   b_addr;
  logic [DATA_W-1:0] a_wdata,  b_wdata;
  logic              a_gnt,    b_gnt;
  logic              a_rvalid, b_rvalid;
  logic [DATA_W-1:0] a_rdata,  b_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    output a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_addr, b_addr, a_wdata, b_wdata, mem_rdata,
    input  a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/img_mem_arbiter.sv
// ------------------------------------------------------------------
// img_mem_arbiter: round-robin, burst-bounded sharing of the image memory. rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module img_mem_arbiter
  import coproc_pkg::*;
#(
  parameter int ADDR_W    = IMG_ADDR_W,
  parameter int DATA_W    = IMG_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  img_mem_arbiter_if.slave   bus
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state, state_nx;
  owner_t           last_owner, last_owner_nx;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nx;
  logic             rd_tag_a, rd_tag_b;

  logic              beat_a, beat_b, at_limit;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign beat_a   = (state == ST_OWN_A) & bus.a_req;
  assign beat_b   = (state == ST_OWN_B) & bus.b_req;
  assign at_limit = (beat_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_owner <= OWNER_B;
      beat_cnt   <= '0;
      rd_tag_a   <= 1'b0;
      rd_tag_b   <= 1'b0;
    end else begin
      state      <= state_nx;
      last_owner <= last_owner_nx;
      beat_cnt   <= beat_cnt_nx;
      rd_tag_a   <= beat_a & ~bus.a_we;
      rd_tag_b   <= beat_b & ~bus.b_we;
    end
  end

  always_comb begin
    state_nx      = state;
    beat_cnt_nx   = beat_cnt;
    last_owner_nx = last_owner;
    unique case (state)
      ST_IDLE: begin
        if (bus.a_req && bus.b_req)
          state_nx = (last_owner == OWNER_A) ? ST_OWN_B : ST_OWN_A;
        else if (bus.a_req)
          state_nx = ST_OWN_A;
        else if (bus.b_req)
          state_nx = ST_OWN_B;
      end
      ST_OWN_A: begin
        if (bus.a_req) begin
          if (at_limit) begin
            beat_cnt_nx = '0;
            if (bus.b_req) state_nx = ST_OWN_B;
          end else begin
            beat_cnt_nx = beat_cnt + CNT_W'(1);
          end
        end else begin
          // Release bubble: hand over without a beat.
          beat_cnt_nx = '0;
          state_nx    = bus.b_req ? ST_OWN_B : ST_IDLE;
        end
      end
      ST_OWN_B: begin
        if (bus.b_req) begin
          if (at_limit) begin
            beat_cnt_nx = '0;
            if (bus.a_req) state_nx = ST_OWN_A;
          end else begin
            beat_cnt_nx = beat_cnt + CNT_W'(1);
          end
        end else begin
          beat_cnt_nx = '0;
          state_nx    = bus.a_req ? ST_OWN_A : ST_IDLE;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        beat_cnt_nx = '0;
      end
    endcase
    if (state_nx == ST_OWN_A && state != ST_OWN_A) last_owner_nx = OWNER_A;
    if (state_nx == ST_OWN_B && state != ST_OWN_B) last_owner_nx = OWNER_B;
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (beat_a) begin
      addr_mux  = bus.a_addr;
      wdata_mux = bus.a_wdata;
    end else if (beat_b) begin
      addr_mux  = bus.b_addr;
      wdata_mux = bus.b_wdata;
    end
  end

  assign bus.a_gnt     = (state == ST_OWN_A);
  assign bus.b_gnt     = (state == ST_OWN_B);
  assign bus.mem_en    = beat_a | beat_b;
  assign bus.mem_we    = (beat_a & bus.a_we) | (beat_b & bus.b_we);
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.a_rvalid  = rd_tag_a;
  assign bus.b_rvalid  = rd_tag_b;
  assign bus.a_rdata   = bus.mem_rdata;
  assign bus.b_rdata   = bus.mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_img_mem_arbiter.sv
// ------------------------------------------------------------------
// tb_img_mem_arbiter: directed stimulus with a cycle-level reference model.
// ------------------------------------------------------------------
`default_nettype none

module tb_img_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  img_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  img_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Memory macro: one-cycle read latency, preset contents while in reset
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rdata_q;
  assign bus.mem_rdata = rdata_q;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i ^ 8'hA5);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= mem[bus.mem_addr];
    end
  end

  // Reference model: owner 0=none 1=A 2=B, run = beats taken in current tenure
  int            m_own = 0, m_last = 2, m_run = 0;
  bit            m_tag_a = 0, m_tag_b = 0;
  logic [DW-1:0] m_rd = '0;
  logic [DW-1:0] ref_mem [256];

  always @(negedge clk) begin
    bit            ea_gnt, eb_gnt, ba, bb, e_en, e_we, mine, other;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    int            nown, oth;
    if (reset) begin
      m_own = 0; m_last = 2; m_run = 0; m_tag_a = 0; m_tag_b = 0;
      for (int i = 0; i < 256; i++) ref_mem[i] = DW'(i ^ 8'hA5);
    end
    ea_gnt  = (m_own == 1);
    eb_gnt  = (m_own == 2);
    ba      = ea_gnt && bus.a_req;
    bb      = eb_gnt && bus.b_req;
    e_en    = ba || bb;
    e_we    = ba ? bus.a_we    : (bb ? bus.b_we    : 1'b0);
    e_addr  = ba ? bus.a_addr  : (bb ? bus.b_addr  : '0);
    e_wdata = ba ? bus.a_wdata : (bb ? bus.b_wdata : '0);

    chk("a_gnt",     bus.a_gnt,     ea_gnt);
    chk("b_gnt",     bus.b_gnt,     eb_gnt);
    chk("mem_en",    bus.mem_en,    e_en);
    chk("mem_we",    bus.mem_we,    e_we);
    chk("mem_addr",  bus.mem_addr,  e_addr);
    chk("mem_wdata", bus.mem_wdata, e_wdata);
    chk("a_rvalid",  bus.a_rvalid,  m_tag_a);
    chk("b_rvalid",  bus.b_rvalid,  m_tag_b);
    if (m_tag_a) chk("a_rdata", bus.a_rdata, m_rd);
    if (m_tag_b) chk("b_rdata", bus.b_rdata, m_rd);

    if (!reset) begin
      if (e_en && !e_we) m_rd = ref_mem[e_addr];
      if (e_en && e_we) ref_mem[e_addr] = e_wdata;
      m_tag_a = ba && !bus.a_we;
      m_tag_b = bb && !bus.b_we;
      nown = m_own;
      if (m_own == 0) begin
        if (bus.a_req && bus.b_req) nown = (m_last == 1) ? 2 : 1;
        else if (bus.a_req)         nown = 1;
        else if (bus.b_req)         nown = 2;
      end else begin
        mine  = (m_own == 1) ? bus.a_req : bus.b_req;
        other = (m_own == 1) ? bus.b_req : bus.a_req;
        oth   = 3 - m_own;
        if (mine) begin
          m_run++;
          if (m_run == MB) begin
            m_run = 0;
            if (other) nown = oth;
          end
        end else begin
          m_run = 0;
          nown  = other ? oth : 0;
        end
      end
      if (nown != 0 && nown != m_own) m_last = nown;
      m_own = nown;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports();
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    string     exp_pat;
    byte       pat [12];
    exp_pat = "AAAABBBBAAAA";
    reset = 1'b1;
    idle_ports();
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_gnt",    {bus.a_gnt, bus.b_gnt}, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_rvalid", {bus.a_rvalid, bus.b_rvalid}, 0);
    cyc();
    reset = 1'b0;

    // A writes 0x11/0x22/0x33 at 0..2
    bus.a_req = 1; bus.a_we = 1; bus.a_addr = 8'd0; bus.a_wdata = 8'h11;
    @(negedge clk);
    chk("lat_gnt_t0", bus.a_gnt, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.a_addr = AW'(i); bus.a_wdata = DW'(8'h11 * (i + 1));
      @(negedge clk);
      chk("wr_a_gnt",  bus.a_gnt, 1);
      chk("wr_mem_we", bus.mem_we, 1);
      chk("wr_addr",   bus.mem_addr, i);
      chk("wr_wdata",  bus.mem_wdata, 8'h11 * (i + 1));
    end
    cyc(); bus.a_req = 0;
    cyc();

    // A writes 0x5A at 5, then B reads it back
    bus.a_req = 1; bus.a_addr = 8'd5; bus.a_wdata = 8'h5A;
    cyc(); cyc(); bus.a_req = 0; bus.a_we = 0;
    cyc(); cyc();
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'd5;
    cyc();
    @(negedge clk);
    chk("b_rd_en", {bus.b_gnt, bus.mem_en, bus.mem_we}, 3'b110);
    cyc(); bus.b_req = 0;
    @(negedge clk);
    chk("b_rvalid_5", bus.b_rvalid, 1);
    chk("b_rdata_5",  bus.b_rdata, 8'h5A);
    chk("a_rvalid_0", bus.a_rvalid, 0);
    cyc();
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 8'd1;
    cyc(); cyc(); bus.a_req = 0;
    @(negedge clk);
    chk("a_rdata_1", bus.a_rdata, 8'h22);
    cyc(); cyc();

    // Both saturated from reset: A first, bursts of MB, no gaps
    reset = 1; cyc(); reset = 0;
    bus.a_req = 1; bus.b_req = 1; bus.a_we = 0; bus.b_we = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      bus.a_addr = AW'(i); bus.b_addr = AW'(16 + i);
      @(negedge clk);
      pat[i] = bus.a_gnt ? "A" : (bus.b_gnt ? "B" : "-");
      chk("sat_en", bus.mem_en, 1);
    end
    for (int i = 0; i < 12; i++) chk("sat_pattern", pat[i], exp_pat[i]);
    idle_ports();
    cyc(); cyc(); cyc();

    // A releases after 2 beats with B waiting
    reset = 1; cyc(); reset = 0;
    bus.a_req = 1; bus.b_req = 1;
    cyc(); cyc();
    cyc(); bus.a_req = 0;
    @(negedge clk);
    chk("bubble", {bus.a_gnt, bus.b_gnt, bus.mem_en}, 3'b100);
    cyc(); bus.a_req = 1;
    @(negedge clk);
    chk("rel_b_gnt", bus.b_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      chk("rel_b_burst", bus.b_gnt, 1);
    end
    cyc();
    @(negedge clk);
    chk("rel_back_a", bus.a_gnt, 1);
    idle_ports();
    cyc(); cyc(); cyc();

    // B alone for 10 write beats
    bus.b_req = 1; bus.b_we = 1; bus.b_addr = 8'd100; bus.b_wdata = 8'd0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.b_addr = AW'(100 + i); bus.b_wdata = DW'(i);
      @(negedge clk);
      chk("b_solo", {bus.b_gnt, bus.mem_en, bus.mem_addr}, {2'b11, 8'(100 + i)});
    end
    cyc(); bus.b_req = 0;
    cyc(); cyc();

    // Reset the cycle after a read beat drops the response
    bus.b_req = 1; bus.b_we = 0; bus.b_addr = 8'd5;
    cyc();
    @(negedge clk);
    chk("pre_rst_beat", bus.mem_en, 1);
    cyc(); reset = 1; bus.b_req = 0;
    @(negedge clk);
    chk("rst_drop", {bus.a_gnt, bus.b_gnt, bus.a_rvalid, bus.b_rvalid, bus.mem_en,
                     bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    cyc(); reset = 0;
    bus.a_req = 1; bus.b_req = 1;
    cyc();
    @(negedge clk);
    chk("post_rst_tie", {bus.a_gnt, bus.b_gnt}, 2'b10);
    idle_ports();
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
